sram_dump_streamer: RTL
=======================

Name: sram_dump_streamer

Overview:
- Bulk-read engine between the SRAM driver and the UART transmitter.
- On a command it reads `cmd_len` consecutive bytes from SRAM starting at `cmd_addr` and streams each one out through `uart_tx`.
- Optionally appends an 8-bit additive checksum byte.
- Removes per-byte serial round trips when dumping the 8 KB SRAM. It prefetches the next SRAM byte while the current byte is on the wire.

Parameters:
- SEND_SUM, 1, when 1 a checksum byte is transmitted after the last data byte.
- ADDR_W, 13, SRAM address width (8 KB part).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- cmd_start  in  1  one-cycle request; samples cmd_addr/cmd_len when idle.
- cmd_addr  in  ADDR_W  first SRAM address.
- cmd_len  in  ADDR_W+1  byte count, 0..8192.
- cmd_abort  in  1  level; stop the dump early.
- busy  out  1  high from accepted cmd_start until done.
- done  out  1  one-cycle pulse at completion or abort.
- aborted  out  1  valid with done; 1 if terminated by cmd_abort.
- checksum  out  8  running sum of data bytes sent; held after done.
- ram_ready  in  1  sram_driver idle/ready.
- ram_re  out  1  read select to sram_driver; 1 whenever this block owns the driver.
- ram_start  out  1  one-cycle start pulse to sram_driver.
- ram_address  out  ADDR_W  address for the current read.
- ram_data_read  in  8  sram_driver read data; valid when ram_ready returns high.
- tx_ready  in  1  uart_tx ready.
- tx_start  out  1  strobe to uart_tx.
- tx_data  out  8  byte to uart_tx.

Behaviour:
- Reset values: all outputs 0, both FSMs idle, buffer empty, counters 0.
- Control (IDLE/RUN/DRAIN):
  - IDLE + cmd_start: latch addr and len, reads_left=len, sends_left=len, checksum=0, busy=1, go to RUN.
  - cmd_start while busy is ignored.
- Read FSM (R_IDLE, R_WAIT_LOW, R_WAIT_HIGH):
  - In RUN with reads_left>0, buffer empty and ram_ready=1: pulse ram_start for 1 cycle with ram_address=addr, then go to R_WAIT_LOW.
  - R_WAIT_LOW waits for ram_ready=0. Driver ready can lag start by 1–2 cycles, so ram_ready is never sampled high in the start cycle.
  - R_WAIT_HIGH waits for ram_ready=1, then captures ram_data_read into the 1-entry buffer and sets buf_valid.
  - On capture: addr+=1, reads_left-=1.
  - Address wraps 0x1FFF→0x0000.
- TX FSM (T_IDLE, T_WAIT_LOW, T_WAIT_HIGH):
  - When buf_valid=1 and tx_ready=1: tx_data=buffer, tx_start=1, buf_valid cleared the same cycle (frees the prefetch slot), checksum+=buffer mod 256, then go to T_WAIT_LOW.
  - tx_start stays high until tx_ready is seen low; uart_tx drops ready 2 cycles after start. Then T_WAIT_HIGH waits for tx_ready=1 and decrements sends_left.
- Overlap: the next SRAM read may begin while the previous byte is still in T_WAIT_*. Bytes are emitted strictly in address order; no byte is dropped or duplicated.
- Completion:
  - When sends_left reaches 0: if SEND_SUM, send the checksum byte through the same TX handshake; the checksum byte itself is not added.
  - Then pulse done, busy=0, return to IDLE.
  - len=0: no SRAM reads; checksum 0x00 sent if SEND_SUM; done.
- Abort (sampled in RUN):
  - No new ram_start or tx_start is issued.
  - An in-flight SRAM read and any UART byte already started are completed.
  - A buffered byte not yet started is discarded; the checksum byte is not sent.
  - Then done=1, aborted=1, IDLE.
  - cmd_abort in IDLE has no effect.
- ram_re=1 and ram_start pulses occur only while busy; outside busy both are 0.
- rstn low mid-operation: immediate return to reset values; a partial UART byte may be truncated (acceptable).

Test Plan:
- SRAM model preloaded addr 0x0010..0x0013 = 0x11,0x22,0x33,0x44; cmd_addr=0x0010, len=4, SEND_SUM=1 -> uart sees 0x11,0x22,0x33,0x44,0xAA; checksum=0xAA; one done pulse, aborted=0.
- cmd_addr=0x1FFE, len=4 -> ram_address sequence 0x1FFE,0x1FFF,0x0000,0x0001; 4 data bytes in that order.
- len=0 -> no ram_start pulses; single uart byte 0x00; done within 3 cycles of last tx_ready rise.
- Driver model with ram_ready drop delayed 2 cycles and uart byte time 100 cycles; len=8 -> each ram_start has exactly one capture; read of byte n+1 completes before byte n finishes transmitting; 8+1 bytes total.
- cmd_abort asserted during the 3rd byte's transmission, len=10 -> 3rd byte completes, no further tx_start or ram_start, no checksum byte, done=1 with aborted=1.
- cmd_start pulsed again while busy -> ignored; rstn pulsed low mid-dump -> all outputs 0 next cycle; a fresh cmd_start after reset runs normally.

Source files
------------

// File: rtl/sram_dump_streamer.sv
// sram_dump_streamer: bulk SRAM-to-UART dump engine.
// Reads cmd_len bytes starting at cmd_addr through the SRAM driver and sends
// each one through the UART transmitter. An optional additive checksum byte
// follows the data. A one-entry buffer lets the next SRAM read overlap the
// byte currently on the wire.
module sram_dump_streamer #(
    parameter int SEND_SUM = 1,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              cmd_abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [7:0]        checksum,
    input  logic              ram_ready,
    output logic              ram_re,
    output logic              ram_start,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [7:0]        ram_data_read,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data
);

    // Control states
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_RUN   = 2'd1;
    localparam logic [1:0] C_DRAIN = 2'd2;

    // Read FSM states
    localparam logic [1:0] R_IDLE      = 2'd0;
    localparam logic [1:0] R_WAIT_LOW  = 2'd1;
    localparam logic [1:0] R_WAIT_HIGH = 2'd2;

    // TX FSM states
    localparam logic [1:0] T_IDLE      = 2'd0;
    localparam logic [1:0] T_WAIT_LOW  = 2'd1;
    localparam logic [1:0] T_WAIT_HIGH = 2'd2;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic              SUM_EN   = (SEND_SUM != 0);

    logic [1:0]        ctrl_state;
    logic [1:0]        rd_state;
    logic [1:0]        tx_state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   reads_left;
    logic [ADDR_W:0]   sends_left;
    logic [7:0]        buf_data;
    logic              buf_valid;
    logic              tx_is_sum;
    logic              sum_sent;

    logic running;
    logic accept;
    logic rd_issue;
    logic rd_capture;
    logic tx_take_data;
    logic tx_take_sum;
    logic finish_ok;
    logic finish_abort;

    // Owning the driver is exactly the busy window, including the drain after abort.
    assign ram_re = busy;

    // Handshake strobes shared by the three state machines.
    // NOTE: combinational logic uses blocking '=' and assigns every signal on
    // every path, so no latch is inferred.
    always_comb begin
        running      = (ctrl_state == C_RUN) && !cmd_abort;
        accept       = (ctrl_state == C_IDLE) && cmd_start;
        rd_issue     = running && (rd_state == R_IDLE) && (reads_left != '0)
                       && !buf_valid && ram_ready;
        rd_capture   = (rd_state == R_WAIT_HIGH) && ram_ready;
        tx_take_data = running && (tx_state == T_IDLE) && buf_valid && tx_ready;
        tx_take_sum  = running && (tx_state == T_IDLE) && !buf_valid && SUM_EN
                       && (sends_left == '0) && !sum_sent && tx_ready;
        finish_ok    = running && (tx_state == T_IDLE) && (sends_left == '0)
                       && (!SUM_EN || sum_sent);
        finish_abort = (ctrl_state == C_DRAIN) && (rd_state == R_IDLE)
                       && (tx_state == T_IDLE);
    end

    // Control FSM: command acceptance, abort drain and completion pulse.
    // NOTE: sequential state uses non-blocking '<=' so every block sees the
    // pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_state <= C_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (ctrl_state)
                C_IDLE: begin
                    if (accept) begin
                        ctrl_state <= C_RUN;
                        busy       <= 1'b1;
                    end
                end
                C_RUN: begin
                    if (cmd_abort) begin
                        ctrl_state <= C_DRAIN;
                    end else if (finish_ok) begin
                        ctrl_state <= C_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                C_DRAIN: begin
                    // Wait for the in-flight SRAM read and UART byte to finish.
                    if (finish_abort) begin
                        ctrl_state <= C_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        aborted    <= 1'b1;
                    end
                end
                default: ctrl_state <= C_IDLE;
            endcase
        end
    end

    // Read FSM: issue one SRAM read at a time into the one-entry prefetch buffer.
    // NOTE: the buffer is a single register, so it is reset with the rest of
    // the state; a multi-entry storage array would be left unreset instead.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state    <= R_IDLE;
            ram_start   <= 1'b0;
            ram_address <= '0;
            addr        <= '0;
            reads_left  <= '0;
            buf_data    <= 8'h00;
            buf_valid   <= 1'b0;
        end else begin
            ram_start <= 1'b0;
            if (accept) begin
                addr       <= cmd_addr;
                reads_left <= cmd_len;
                buf_valid  <= 1'b0;
            end
            // The TX side frees the slot; an abort discards an unsent byte.
            if (tx_take_data || (ctrl_state == C_DRAIN)
                || ((ctrl_state == C_RUN) && cmd_abort)) begin
                buf_valid <= 1'b0;
            end
            case (rd_state)
                R_IDLE: begin
                    if (rd_issue) begin
                        ram_start   <= 1'b1;
                        ram_address <= addr;
                        rd_state    <= R_WAIT_LOW;
                    end
                end
                R_WAIT_LOW: begin
                    // The driver may still look ready for a cycle or two after start.
                    if (!ram_ready) begin
                        rd_state <= R_WAIT_HIGH;
                    end
                end
                R_WAIT_HIGH: begin
                    if (rd_capture) begin
                        buf_data   <= ram_data_read;
                        buf_valid  <= running;
                        addr       <= addr + ADDR_ONE;
                        reads_left <= reads_left - CNT_ONE;
                        rd_state   <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // TX FSM: hand buffered bytes (then the checksum) to the UART.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state   <= T_IDLE;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            checksum   <= 8'h00;
            sends_left <= '0;
            tx_is_sum  <= 1'b0;
            sum_sent   <= 1'b0;
        end else begin
            if (accept) begin
                sends_left <= cmd_len;
                checksum   <= 8'h00;
                sum_sent   <= 1'b0;
            end
            case (tx_state)
                T_IDLE: begin
                    if (tx_take_data) begin
                        tx_data   <= buf_data;
                        tx_start  <= 1'b1;
                        checksum  <= checksum + buf_data;
                        tx_is_sum <= 1'b0;
                        tx_state  <= T_WAIT_LOW;
                    end else if (tx_take_sum) begin
                        tx_data   <= checksum;
                        tx_start  <= 1'b1;
                        tx_is_sum <= 1'b1;
                        tx_state  <= T_WAIT_LOW;
                    end
                end
                T_WAIT_LOW: begin
                    // Hold the strobe until the UART acknowledges by dropping ready.
                    if (!tx_ready) begin
                        tx_start <= 1'b0;
                        tx_state <= T_WAIT_HIGH;
                    end
                end
                T_WAIT_HIGH: begin
                    if (tx_ready) begin
                        tx_state <= T_IDLE;
                        if (tx_is_sum) begin
                            sum_sent <= 1'b1;
                        end else begin
                            sends_left <= sends_left - CNT_ONE;
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

endmodule
